// File: rtl/mem_port_arbiter.sv
// Two-requester arbiter (fetch and load/store) in front of a single-port memory.
// Serialises requests, routes responses back to the issuer, guards IF starvation and times out stuck accesses.
module mem_port_arbiter #(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int STARVE_LIMIT = 4,
  parameter int TIMEOUT      = 16
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_valid,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_err,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_gnt,
  output logic              d_valid,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_err,
  output logic              m_req,
  output logic              m_we,
  output logic [ADDR_W-1:0] m_addr,
  output logic [DATA_W-1:0] m_wdata,
  input  logic              m_ack,
  input  logic [DATA_W-1:0] m_rdata
);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] BUSY = 1'b1;

  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam int WW = $clog2(TIMEOUT);
  localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);
  localparam logic [WW-1:0] WAIT_LAST  = WW'(TIMEOUT - 1);

  logic [0:0]    state_reg;
  logic          owner_if_reg;
  logic [SW-1:0] starve_cnt_reg;
  logic [WW-1:0] wait_cnt_reg;

  logic              starve_full;
  logic              win_if;
  logic              done;
  logic [DATA_W-1:0] resp_rdata;

  // D has priority unless IF has already lost STARVE_LIMIT times in a row.
  assign starve_full = (starve_cnt_reg == STARVE_MAX);
  assign win_if      = if_req && (!d_req || starve_full);

  // An ack on the last wait cycle still completes cleanly.
  assign done       = m_ack || (wait_cnt_reg == WAIT_LAST);
  assign resp_rdata = (m_ack && !m_we) ? m_rdata : '0;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_reg      <= IDLE;
      owner_if_reg   <= 1'b0;
      starve_cnt_reg <= '0;
      wait_cnt_reg   <= '0;
      if_gnt         <= 1'b0;
      if_valid       <= 1'b0;
      if_rdata       <= '0;
      if_err         <= 1'b0;
      d_gnt          <= 1'b0;
      d_valid        <= 1'b0;
      d_rdata        <= '0;
      d_err          <= 1'b0;
      m_req          <= 1'b0;
      m_we           <= 1'b0;
      m_addr         <= '0;
      m_wdata        <= '0;
    end else begin
      if_gnt   <= 1'b0;
      d_gnt    <= 1'b0;
      if_valid <= 1'b0;
      d_valid  <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (if_req || d_req) begin
            state_reg    <= BUSY;
            owner_if_reg <= win_if;
            m_req        <= 1'b1;
            m_we         <= win_if ? 1'b0 : d_we;
            m_addr       <= win_if ? if_addr : d_addr;
            m_wdata      <= win_if ? '0 : d_wdata;
            if_gnt       <= win_if;
            d_gnt        <= !win_if;
            wait_cnt_reg <= '0;
            if (win_if)
              starve_cnt_reg <= '0;
            else if (if_req && !starve_full)
              starve_cnt_reg <= starve_cnt_reg + SW'(1);
          end
        end
        BUSY: begin
          if (done) begin
            state_reg <= IDLE;
            m_req     <= 1'b0;
            if (owner_if_reg) begin
              if_valid <= 1'b1;
              if_rdata <= resp_rdata;
              if_err   <= !m_ack;
            end else begin
              d_valid <= 1'b1;
              d_rdata <= resp_rdata;
              d_err   <= !m_ack;
            end
          end else begin
            wait_cnt_reg <= wait_cnt_reg + WW'(1);
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule
